aes_enc_round_sequencer: RTL and testbench

Encryption-side counterpart of the decryptor AddRoundKey stage. Sequences one AES-128 block through the full 11-key encryption schedule. It performs the initial AddRoundKey on the plaintext, then for rounds 1..NR hands state to an external round-transform unit (SubBytes/ShiftRows/MixColumns) and XORs the returned state with the round key. Round keys come from the key-expansion block over a request/valid interface. The block sits between the plaintext source and the ciphertext sink of the encryptor top.

---
 rtl/aes_enc_pkg.sv | 21 ++
 rtl/aes_enc_round_sequencer.sv | 107 ++++++++++
 tb/tb_aes_enc_round_sequencer.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_enc_pkg.sv
// Shared types and constants for the AES-128 encryption round sequencer.
//   NR_AES128 : number of AES-128 rounds (round keys 0..NR_AES128)
//   BLOCK_W   : block / round-key width in bits
//   round_t   : round / key index, wide enough for 0..NR_AES128
//   seq_state_e : sequencer FSM states
package aes_enc_pkg;

  localparam int unsigned NR_AES128 = 10;
  localparam int unsigned BLOCK_W   = 128;

  typedef logic [3:0] round_t;

  typedef enum logic [2:0] {
    StIdle,
    StKey,
    StRtStart,
    StRtWait,
    StDone
  } seq_state_e;

endpackage

// File: rtl/aes_enc_round_sequencer.sv
// Sequences one AES-128 block through the encryption key schedule: initial AddRoundKey on the
// plaintext, then for rounds 1..NR an external round transform followed by AddRoundKey.
// Ports:
//   Clk, Rst            clock; synchronous active-low reset
//   In_Valid/In_Ready   plaintext handshake, Plaintext block
//   Key_Req/Key_Idx     round-key request (held until Key_Valid), Round_Key returned
//   Rt_Start/Rt_Last    one-cycle start pulse to the round transform; Rt_Last = final round
//   Rt_Out              state sent to the transform, Rt_Done/Rt_In its result
//   Out_Valid/Out_Ready ciphertext handshake, Ciphertext block
module aes_enc_round_sequencer
  import aes_enc_pkg::*;
#(
  parameter int unsigned NR = NR_AES128,
  parameter int unsigned W  = BLOCK_W
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         In_Valid,
  output logic         In_Ready,
  input  logic [W-1:0] Plaintext,
  output logic         Key_Req,
  output logic [3:0]   Key_Idx,
  input  logic         Key_Valid,
  input  logic [W-1:0] Round_Key,
  output logic         Rt_Start,
  output logic         Rt_Last,
  output logic [W-1:0] Rt_Out,
  input  logic         Rt_Done,
  input  logic [W-1:0] Rt_In,
  output logic         Out_Valid,
  input  logic         Out_Ready,
  output logic [W-1:0] Ciphertext
);

  localparam round_t LastRound = round_t'(NR);

  seq_state_e   fsm_q, fsm_d;
  round_t       round_q, round_d;
  logic [W-1:0] state_q, state_d;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      fsm_q   <= StIdle;
      round_q <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    unique case (fsm_q)
      StIdle: begin
        if (In_Valid) begin
          state_d = Plaintext;
          round_d = '0;
          fsm_d   = StKey;
        end
      end
      StKey: begin
        if (Key_Valid) begin
          state_d = state_q ^ Round_Key;
          // The key for round NR closes the block; no transform follows it.
          if (round_q == LastRound) begin
            fsm_d = StDone;
          end else begin
            round_d = round_q + round_t'(1);
            fsm_d   = StRtStart;
          end
        end
      end
      StRtStart: begin
        fsm_d = StRtWait;
      end
      StRtWait: begin
        if (Rt_Done) begin
          state_d = Rt_In;
          fsm_d   = StKey;
        end
      end
      StDone: begin
        if (Out_Ready) begin
          fsm_d = StIdle;
        end
      end
      default: begin
        fsm_d = StIdle;
      end
    endcase
  end

  assign In_Ready   = (fsm_q == StIdle);
  assign Key_Req    = (fsm_q == StKey);
  assign Key_Idx    = round_q;
  assign Rt_Start   = (fsm_q == StRtStart);
  // round_q was already advanced on leaving StKey, so it names the round being transformed.
  assign Rt_Last    = (fsm_q == StRtStart) && (round_q == LastRound);
  assign Rt_Out     = state_q;
  assign Out_Valid  = (fsm_q == StDone);
  assign Ciphertext = state_q;

endmodule

// File: tb/tb_aes_enc_round_sequencer.sv
module tb_aes_enc_round_sequencer;

  localparam int unsigned W = 128;

  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R0_C1 = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         In_Valid = 1'b0;
  logic         In_Ready;
  logic [W-1:0] Plaintext = '0;
  logic         Key_Req;
  logic [3:0]   Key_Idx;
  logic         Key_Valid = 1'b0;
  logic [W-1:0] Round_Key = '0;
  logic         Rt_Start;
  logic         Rt_Last;
  logic [W-1:0] Rt_Out;
  logic         Rt_Done = 1'b0;
  logic [W-1:0] Rt_In = '0;
  logic         Out_Valid;
  logic         Out_Ready = 1'b0;
  logic [W-1:0] Ciphertext;

  aes_enc_round_sequencer #(.NR(10), .W(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Plaintext (Plaintext),
    .Key_Req   (Key_Req),
    .Key_Idx   (Key_Idx),
    .Key_Valid (Key_Valid),
    .Round_Key (Round_Key),
    .Rt_Start  (Rt_Start),
    .Rt_Last   (Rt_Last),
    .Rt_Out    (Rt_Out),
    .Rt_Done   (Rt_Done),
    .Rt_In     (Rt_In),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Ciphertext(Ciphertext)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // ---------------- AES reference pieces for the external units ----------------
  logic [7:0]   sbox [256];
  logic [127:0] rk [2][11];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] rt_model(input logic [127:0] s, input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   m [16];
    logic [127:0] r;
    for (int n = 0; n < 16; n++) a[n] = sbox[s[127-8*n -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) b[rr+4*c] = a[rr+4*((c+rr)%4)];
    for (int c = 0; c < 4; c++) begin
      m[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
      m[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
    end
    for (int n = 0; n < 16; n++) r[127-8*n -: 8] = last ? b[n] : m[n];
    return r;
  endfunction

  function automatic void expand_key(input logic [127:0] key, input int set);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[set][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- control knobs written only by the test tasks ----------------
  bit key_hold = 1'b0;
  bit stall_en = 1'b0;
  bit spur_en  = 1'b0;
  int rt_long  = 0;
  int key_set_plan [16];

  // ---------------- key-expansion model (negedge driven) ----------------
  int         key_blk = 0;
  int         key_set = 0;
  int         key_wait = 0;
  bit         key_prev_wait = 1'b0;
  logic [3:0] key_prev_idx = '0;
  int         key_viol = 0;
  int         key_log [$];

  always @(negedge Clk) begin
    Key_Valid = 1'b0;
    if (!Rst) begin
      key_wait      = 0;
      key_prev_wait = 1'b0;
    end else if (Key_Req === 1'b1) begin
      if (key_prev_wait && Key_Idx !== key_prev_idx) key_viol++;
      if (key_wait == 0 && !(key_hold && Key_Idx != 4'd0)) begin
        if (Key_Idx == 4'd0) begin
          key_set = key_set_plan[key_blk % 16];
          key_blk++;
        end
        Key_Valid = 1'b1;
        Round_Key = rk[key_set][Key_Idx];
        key_log.push_back(int'(Key_Idx));
        key_wait = stall_en ? int'($urandom_range(0, 7)) : 0;
        key_prev_wait = 1'b0;
      end else begin
        if (key_wait > 0) key_wait--;
        key_prev_wait = 1'b1;
        key_prev_idx  = Key_Idx;
      end
    end else begin
      key_prev_wait = 1'b0;
      if (spur_en && $urandom_range(0, 1) == 1) begin
        Key_Valid = 1'b1;
        Round_Key = {4{$urandom}};
      end
    end
  end

  // ---------------- round-transform model (negedge driven) ----------------
  bit           rt_pend = 1'b0;
  int           rt_wait = 0;
  logic [127:0] rt_res = '0;
  int           rt_starts = 0;
  int           rt_viol = 0;
  bit           rt_prev_start = 1'b0;
  bit           rt_last_log [$];

  always @(negedge Clk) begin
    Rt_Done = 1'b0;
    if (!Rst) begin
      rt_pend       = 1'b0;
      rt_prev_start = 1'b0;
    end else begin
      if (rt_pend) begin
        if (rt_wait == 0) begin
          Rt_Done = 1'b1;
          Rt_In   = rt_res;
          rt_pend = 1'b0;
        end else begin
          rt_wait--;
        end
      end else if (spur_en && $urandom_range(0, 1) == 1) begin
        Rt_Done = 1'b1;
        Rt_In   = {4{$urandom}};
      end
      if (Rt_Start === 1'b1) begin
        if (rt_pend || rt_prev_start) rt_viol++;
        rt_pend = 1'b1;
        rt_res  = rt_model(Rt_Out, Rt_Last);
        rt_starts++;
        rt_last_log.push_back(Rt_Last);
        rt_wait = (rt_long > 0) ? rt_long : (stall_en ? int'($urandom_range(0, 7)) : 0);
        rt_prev_start = 1'b1;
      end else begin
        rt_prev_start = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers (no comparisons) ----------------
  int blk_no = 0;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_block(input logic [127:0] pt, input int set);
    key_set_plan[blk_no % 16] = set;
    blk_no++;
    Plaintext = pt;
    In_Valid  = 1'b1;
    tick();
    In_Valid  = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 1;
    while (Out_Valid !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Rst = 1'b0;
    repeat (2) tick();
    Rst = 1'b1;
    checks++;
    if ({In_Ready, Out_Valid, Key_Req, Rt_Start, Rt_Last} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 10000",
               {In_Ready, Out_Valid, Key_Req, Rt_Start, Rt_Last});
    end
    checks++;
    if (Key_Idx !== 4'd0 || Ciphertext !== '0) begin
      errors++;
      $display("FAIL reset_data: got idx=%0d ct=%h want idx=0 ct=0", Key_Idx, Ciphertext);
    end
  endtask

  task automatic test_fips();
    int cyc;
    Out_Ready = 1'b1;
    send_block(PT_C1, 0);
    wait_out(cyc);
    checks++;
    if (cyc != 32) begin
      errors++;
      $display("FAIL fips_latency: got cycle %0d want 32", cyc);
    end
    checks++;
    if (Ciphertext !== CT_C1 || In_Ready !== 1'b0) begin
      errors++;
      $display("FAIL fips_ct: got %h rdy=%b want %h rdy=0", Ciphertext, In_Ready, CT_C1);
    end
    tick();
    checks++;
    if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL fips_idle: got ov=%b rdy=%b want ov=0 rdy=1", Out_Valid, In_Ready);
    end
  endtask

  task automatic test_round0();
    int  cyc;
    int  n;
    int  kbase;
    int  rbase;
    bit  bad;
    kbase    = key_log.size();
    rbase    = rt_last_log.size();
    key_hold = 1'b1;
    send_block(PT_C1, 0);
    n = 0;
    while (Rt_Start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (Rt_Start !== 1'b1 || Rt_Out !== R0_C1) begin
      errors++;
      $display("FAIL round0_state: got start=%b out=%h want start=1 out=%h",
               Rt_Start, Rt_Out, R0_C1);
    end
    repeat (12) tick();
    checks++;
    if (Key_Req !== 1'b1 || Key_Idx !== 4'd1) begin
      errors++;
      $display("FAIL round0_hold: got req=%b idx=%0d want req=1 idx=1", Key_Req, Key_Idx);
    end
    key_hold = 1'b0;
    wait_out(cyc);
    checks++;
    if (Out_Valid !== 1'b1 || Ciphertext !== CT_C1) begin
      errors++;
      $display("FAIL round0_ct: got ov=%b ct=%h want ov=1 ct=%h", Out_Valid, Ciphertext, CT_C1);
    end
    bad = (key_log.size() - kbase) != 11;
    if (!bad) for (int i = 0; i < 11; i++) if (key_log[kbase+i] != i) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL key_idx_seq: got %0d keys served, want indices 0..10 in order",
               key_log.size() - kbase);
    end
    bad = (rt_last_log.size() - rbase) != 10;
    if (!bad) for (int i = 0; i < 10; i++) if (rt_last_log[rbase+i] != (i == 9)) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rt_last_seq: got %0d starts, want 10 with Rt_Last only on the 10th",
               rt_last_log.size() - rbase);
    end
    tick();
  endtask

  task automatic test_stalls();
    int cyc;
    int kv;
    int rv;
    int rs;
    kv        = key_viol;
    rv        = rt_viol;
    rs        = rt_starts;
    stall_en  = 1'b1;
    Out_Ready = 1'b0;
    send_block(PT_C1, 0);
    wait_out(cyc);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (Out_Valid !== 1'b1 || Ciphertext !== CT_C1) begin
        errors++;
        $display("FAIL stall_ct_hold[%0d]: got ov=%b ct=%h want ov=1 ct=%h",
                 i, Out_Valid, Ciphertext, CT_C1);
      end
      tick();
    end
    Out_Ready = 1'b1;
    tick();
    checks++;
    if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got ov=%b rdy=%b want ov=0 rdy=1", Out_Valid, In_Ready);
    end
    checks++;
    if (key_viol != kv || rt_viol != rv || rt_starts - rs != 10) begin
      errors++;
      $display("FAIL stall_protocol: got keyviol=%0d rtviol=%0d starts=%0d want 0 0 10",
               key_viol - kv, rt_viol - rv, rt_starts - rs);
    end
    stall_en = 1'b0;
  endtask

  task automatic test_spurious();
    int cyc;
    int kv;
    int rv;
    int rs;
    kv       = key_viol;
    rv       = rt_viol;
    rs       = rt_starts;
    stall_en = 1'b1;
    spur_en  = 1'b1;
    repeat (6) tick();
    checks++;
    if (In_Ready !== 1'b1 || Ciphertext !== CT_C1) begin
      errors++;
      $display("FAIL spur_idle_pre: got rdy=%b ct=%h want rdy=1 ct=%h",
               In_Ready, Ciphertext, CT_C1);
    end
    send_block(PT_B, 1);
    wait_out(cyc);
    checks++;
    if (Out_Valid !== 1'b1 || Ciphertext !== CT_B) begin
      errors++;
      $display("FAIL spur_ct: got ov=%b ct=%h want ov=1 ct=%h", Out_Valid, Ciphertext, CT_B);
    end
    tick();
    repeat (6) tick();
    checks++;
    if (In_Ready !== 1'b1 || Ciphertext !== CT_B) begin
      errors++;
      $display("FAIL spur_idle_post: got rdy=%b ct=%h want rdy=1 ct=%h",
               In_Ready, Ciphertext, CT_B);
    end
    checks++;
    if (key_viol != kv || rt_viol != rv || rt_starts - rs != 10) begin
      errors++;
      $display("FAIL spur_protocol: got keyviol=%0d rtviol=%0d starts=%0d want 0 0 10",
               key_viol - kv, rt_viol - rv, rt_starts - rs);
    end
    spur_en  = 1'b0;
    stall_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    int n;
    int rs;
    rs      = rt_starts;
    rt_long = 3;
    send_block(PT_C1, 0);
    n = 0;
    while (rt_starts - rs < 5 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (rt_starts - rs != 5 || Key_Req !== 1'b0 || Rt_Start !== 1'b0 || Key_Idx !== 4'd5) begin
      errors++;
      $display("FAIL mid_round5: got starts=%0d req=%b st=%b idx=%0d want 5 0 0 5",
               rt_starts - rs, Key_Req, Rt_Start, Key_Idx);
    end
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    rt_long = 0;
    checks++;
    if ({In_Ready, Out_Valid, Key_Req, Rt_Start, Rt_Last} !== 5'b10000 || Key_Idx !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset_flags: got %b idx=%0d want 10000 idx=0",
               {In_Ready, Out_Valid, Key_Req, Rt_Start, Rt_Last}, Key_Idx);
    end
    checks++;
    if (Ciphertext !== '0 || Rt_Out !== '0) begin
      errors++;
      $display("FAIL mid_reset_data: got ct=%h rt=%h want 0", Ciphertext, Rt_Out);
    end
    repeat (8) tick();
    checks++;
    if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_discard: got ov=%b rdy=%b want ov=0 rdy=1", Out_Valid, In_Ready);
    end
    send_block(PT_B, 1);
    wait_out(cyc);
    checks++;
    if (cyc != 32 || Ciphertext !== CT_B) begin
      errors++;
      $display("FAIL mid_new_block: got cycle=%0d ct=%h want 32 %h", cyc, Ciphertext, CT_B);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    Out_Ready = 1'b1;
    key_set_plan[blk_no % 16] = 0;
    key_set_plan[(blk_no + 1) % 16] = 1;
    blk_no += 2;
    Plaintext = PT_C1;
    In_Valid  = 1'b1;
    tick();
    Plaintext = PT_B;
    wait_out(cyc);
    checks++;
    if (Out_Valid !== 1'b1 || Ciphertext !== CT_C1) begin
      errors++;
      $display("FAIL b2b_first_ct: got ov=%b ct=%h want ov=1 ct=%h", Out_Valid, Ciphertext, CT_C1);
    end
    tick();
    checks++;
    if (In_Ready !== 1'b1 || Out_Valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: got rdy=%b ov=%b want rdy=1 ov=0", In_Ready, Out_Valid);
    end
    tick();
    In_Valid = 1'b0;
    checks++;
    if (In_Ready !== 1'b0 || Key_Req !== 1'b1 || Key_Idx !== 4'd0) begin
      errors++;
      $display("FAIL b2b_accept: got rdy=%b req=%b idx=%0d want rdy=0 req=1 idx=0",
               In_Ready, Key_Req, Key_Idx);
    end
    wait_out(cyc);
    checks++;
    if (cyc != 32 || Ciphertext !== CT_B) begin
      errors++;
      $display("FAIL b2b_second_ct: got cycle=%0d ct=%h want 32 %h", cyc, Ciphertext, CT_B);
    end
    tick();
  endtask

  initial begin
    logic [2047:0] sbox_flat;
    sbox_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox[i] = sbox_flat[2047-8*i -: 8];
    for (int i = 0; i < 16; i++) key_set_plan[i] = 0;
    expand_key(K_C1, 0);
    expand_key(K_B, 1);

    test_reset();
    test_fips();
    test_round0();
    test_stalls();
    test_spurious();
    test_reset_mid();
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
